// File: rtl/misc_v_pkg.sv
// Types and constants shared by the fetch and decode stages: machine word
// width, reset-PC default and the PC-tagged instruction entry.
package misc_v_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a 4-byte instruction boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction queue of fetch_entry_t with push, pop, flush and a
// registered head so decode sees flop outputs only.
module fetch_fifo
    import misc_v_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             head_valid_o,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] remain;
    fetch_entry_t     head_q, head_d;
    logic             head_valid_q, head_valid_d;
    logic             do_pop;
    logic             do_write;

    // Next pointers, occupancy and head; the head is refilled from storage, or
    // straight from the push port when the queue would otherwise be empty.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        do_pop   = pop_i && head_valid_q;
        do_write = push_i && !flush_i;
        remain   = count_q - CNT_W'(do_pop);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = remain + CNT_W'(push_i);
            if (remain != '0) begin
                head_d = mem_q[rd_ptr_d];
            end else if (push_i) begin
                head_d = push_entry_i;
            end
        end
        head_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    // Storage needs no reset; only slots inside count are ever read.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_valid_o = head_valid_q;
    assign head_o       = head_q;
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word
// requests, queues responses for decode and drops stale words after redirects.
module fetch_unit
    import misc_v_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] fifo_count;
    logic [XLEN-1:0]  target;
    logic             req_fire;
    logic             rsp_drop;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // A request is only issued when a queue slot is already reserved for it.
    assign req_valid = (SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH);
    assign req_fire  = req_valid && req_ready;
    assign rsp_drop  = rsp_valid && (drop_q != '0);
    assign push      = rsp_valid && !rsp_drop && !redirect_valid;
    assign pop       = inst_valid && inst_ready;
    assign target    = word_align(redirect_pc);

    assign push_entry = '{pc: rsp_pc_q, instr: rsp_data};

    // On redirect every word still owed after this edge becomes a drop,
    // which already covers any drops pending from earlier redirects.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            drop_d     = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + INST_BYTES;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + INST_BYTES;
            end
            if (rsp_drop) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_valid_o (inst_valid),
        .head_o       (head),
        .count_o      (fifo_count)
    );

    assign req_addr  = fetch_pc_q;
    assign inst_data = head.instr;
    assign inst_pc   = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model feeds the
// DUT and a scoreboard of expected PCs checks every word handed to decode.
module tb_fetch_unit;
    import misc_v_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    int dcount = 0;
    int lat = 1;
    int edge_idx = 0;
    int req_count = 0;
    int snap;
    logic [31:0] exp_q[$];
    logic [31:0] maddr_q[$];
    int          mdue_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[9:2], a[31:8]};
    endfunction

    function automatic void push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i * 4));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_deliv(input int n, input string tag);
        int target;
        int k;
        target = dcount + n;
        k = 0;
        while (dcount < target && k < 300) begin
            step();
            k++;
        end
        check(tag, 32'(dcount >= target), 32'd1);
    endtask

    // Instruction memory: in order, fixed latency per request, cleared by reset.
    always @(negedge clk) begin
        if (reset) begin
            maddr_q.delete();
            mdue_q.delete();
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end else begin
            rsp_valid = 1'b0;
            if (mdue_q.size() > 0 && mdue_q[0] <= edge_idx) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_word(maddr_q[0]);
                void'(maddr_q.pop_front());
                void'(mdue_q.pop_front());
            end
            if (req_valid && req_ready) begin
                maddr_q.push_back(req_addr);
                mdue_q.push_back(edge_idx + lat);
                req_count++;
            end
        end
        edge_idx++;
    end

    // Scoreboard: every word decode takes must be the next expected PC.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && inst_valid && inst_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_delivery observed=%h expected=none", inst_pc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (inst_pc === e) else begin
                    errors++;
                    $error("FAIL deliv_pc observed=%h expected=%h", inst_pc, e);
                end
                checks++;
                assert (inst_data === mem_word(e)) else begin
                    errors++;
                    $error("FAIL deliv_data observed=%h expected=%h", inst_data, mem_word(e));
                end
            end
            dcount++;
        end
    end

    initial begin
        reset          = 1'b1;
        req_ready      = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) step();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd1);
        check("rst_req_addr", req_addr, RST_PC);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);

        // Streaming from reset with 1-cycle memory.
        push_stream(RST_PC, 64);
        reset = 1'b0;
        step();
        check("first_req_adv", req_addr, RST_PC + 32'd4);
        check("fill_empty", 32'(inst_valid), 32'd0);
        step();
        check("fill_valid", 32'(inst_valid), 32'd1);
        check("fill_pc", inst_pc, RST_PC);
        wait_deliv(3, "stream_start");
        snap = dcount;
        repeat (10) step();
        check("throughput", 32'(dcount - snap), 32'd10);

        // Redirect with decode stalled: exactly DEPTH new requests, then drain.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        inst_ready     = 1'b0;
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'h0000_0300, 64);
        snap = req_count;
        check("stall_flush", 32'(inst_valid), 32'd0);
        repeat (10) step();
        check("stall_req_cnt", 32'(req_count - snap), 32'd4);
        check("stall_req_valid", 32'(req_valid), 32'd0);
        check("stall_head_valid", 32'(inst_valid), 32'd1);
        check("stall_head_pc", inst_pc, 32'h0000_0300);
        inst_ready = 1'b1;
        wait_deliv(12, "stall_drain");

        // Redirect coinciding with a request handshake and a response.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        @(negedge clk);
        #1;
        check("same_req_fire", 32'(req_valid && req_ready), 32'd1);
        check("same_rsp", 32'(rsp_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'h0000_0500, 64);
        check("same_n1_valid", 32'(inst_valid), 32'd0);
        check("same_n1_addr", req_addr, 32'h0000_0500);
        step();
        check("same_n2_valid", 32'(inst_valid), 32'd0);
        step();
        check("same_n3_valid", 32'(inst_valid), 32'd1);
        check("same_n3_pc", inst_pc, 32'h0000_0500);
        wait_deliv(8, "same_stream");

        // Back-to-back redirects: the second target wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        exp_q.delete();
        redirect_pc = 32'h0000_0080;
        check("b2b_n1_valid", 32'(inst_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'h0000_0080, 64);
        check("b2b_n2_valid", 32'(inst_valid), 32'd0);
        check("b2b_addr", req_addr, 32'h0000_0080);
        wait_deliv(4, "b2b_stream");

        // Irregular decode backpressure.
        for (int i = 0; i < 40; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            step();
        end
        inst_ready = 1'b1;
        wait_deliv(4, "bp_stream");

        // Latency 3: three requests in flight, then redirect to an unaligned target.
        reset = 1'b1;
        lat   = 3;
        exp_q.delete();
        step();
        step();
        check("rst2_inst_valid", 32'(inst_valid), 32'd0);
        check("rst2_req_addr", req_addr, RST_PC);
        reset = 1'b0;
        repeat (3) step();
        check("lat3_outstanding", 32'(maddr_q.size()), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        step();
        redirect_valid = 1'b0;
        push_stream(32'h0000_2000, 64);
        check("lat3_flush", 32'(inst_valid), 32'd0);
        check("lat3_addr", req_addr, 32'h0000_2000);
        wait_deliv(6, "lat3_stream");

        // Address wrap, then reset in the middle of the burst.
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'hFFFF_FFF8, 64);
        wait_deliv(3, "wrap_stream");
        check("wrap_burst_valid", 32'(inst_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_inst_valid", 32'(inst_valid), 32'd0);
        check("midrst_req_addr", req_addr, RST_PC);
        check("midrst_req_valid", 32'(req_valid), 32'd1);
        exp_q.delete();
        step();
        step();
        push_stream(RST_PC, 64);
        reset = 1'b0;
        wait_deliv(4, "post_rst_stream");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
